// File: rtl/sm3_compress_core.sv
// SM3 compression core: ROUNDS_PER_CYCLE rounds per clock, internal expansion.
// Optional macro SM3_CV_LOAD_EN adds cv_load_in/cv_in to restore a saved CV.
module sm3_compress_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         block_valid_in,
  output logic         block_ready_out,
  input  logic [511:0] block_in,
  input  logic         first_in,
  input  logic         last_in,
`ifdef SM3_CV_LOAD_EN
  input  logic         cv_load_in,
  input  logic [255:0] cv_in,
`endif
  output logic         busy_out,
  output logic [255:0] digest_out,
  output logic         digest_valid_out
);

  localparam int R = ROUNDS_PER_CYCLE;

  generate
    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_r
      $error("sm3_compress_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [255:0] IV = {
    32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
    32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e
  };

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  logic [1:0]   r_state;
  logic [5:0]   r_j;
  logic [31:0]  r_w [16];
  logic [255:0] r_v;
  logic [255:0] r_cv;
  logic         r_last;
  logic [255:0] r_dig;
  logic         r_dv;

  logic [31:0]  w_w_nxt [16];
  logic [255:0] w_v_nxt;
  logic [255:0] w_cv_src;

  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input logic [4:0]  n
  );
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
  endfunction

  // Extended window: new words may feed later new words in the same cycle.
  always_comb begin
    logic [31:0] e [16+R];
    for (int i = 0; i < 16; i++) e[i] = r_w[i];
    for (int k = 0; k < R; k++) begin
      e[16+k] = p1(e[k] ^ e[k+7] ^ rotl(e[k+13], 5'd15))
              ^ rotl(e[k+3], 5'd7) ^ e[k+10];
    end
    for (int i = 0; i < 16; i++) w_w_nxt[i] = e[i+R];
  end

  always_comb begin
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] ss1, ss2, tt1, tt2, ff, gg, t, a12;
    logic [5:0]  jj;
    {a, b, c, d, e, f, g, h} = r_v;
    for (int k = 0; k < R; k++) begin
      jj = r_j + 6'(k);
      if (jj < 6'd16) begin
        ff = a ^ b ^ c;
        gg = e ^ f ^ g;
        t  = 32'h79cc4519;
      end else begin
        ff = (a & b) | (a & c) | (b & c);
        gg = (e & f) | (~e & g);
        t  = 32'h7a879d8a;
      end
      a12 = rotl(a, 5'd12);
      ss1 = rotl(a12 + e + rotl(t, jj[4:0]), 5'd7);
      ss2 = ss1 ^ a12;
      tt1 = ff + d + ss2 + (r_w[k] ^ r_w[k+4]);
      tt2 = gg + h + ss1 + r_w[k];
      d = c;
      c = rotl(b, 5'd9);
      b = a;
      a = tt1;
      h = g;
      g = rotl(f, 5'd19);
      f = e;
      e = p0(tt2);
    end
    w_v_nxt = {a, b, c, d, e, f, g, h};
  end

`ifdef SM3_CV_LOAD_EN
  assign w_cv_src = cv_load_in ? cv_in : r_cv;
`else
  assign w_cv_src = r_cv;
`endif

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_v     <= '0;
      r_cv    <= IV;
      r_last  <= 1'b0;
      r_dig   <= '0;
      r_dv    <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
`ifdef SM3_CV_LOAD_EN
          if (cv_load_in) r_cv <= cv_in;
`endif
          if (block_valid_in) begin
            for (int i = 0; i < 16; i++) r_w[i] <= block_in[511-32*i -: 32];
            r_v     <= first_in ? IV : w_cv_src;
            if (first_in) r_cv <= IV;
            r_last  <= last_in;
            r_j     <= '0;
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_w <= w_w_nxt;
          r_v <= w_v_nxt;
          r_j <= r_j + 6'(R);
          if (r_j == 6'(64 - R)) r_state <= S_FINAL;
        end
        S_FINAL: begin
          r_cv <= r_cv ^ r_v;
          if (r_last) begin
            r_dig <= r_cv ^ r_v;
            r_dv  <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign block_ready_out  = (r_state == S_IDLE) & ~reset_in;
  assign busy_out         = (r_state != S_IDLE);
  assign digest_out       = r_dig;
  assign digest_valid_out = r_dv;

endmodule
